// File: rtl/fft_pkg.sv
// Shared FFT types and sizes, imported by the FFT core and its sample loader.
package fft_pkg;
   localparam int SAMPLE_W        = 9;
   localparam int NPOINT          = 8;
   localparam int WORDS_PER_FRAME = 2 * NPOINT;
   localparam int WCNT_W          = $clog2(WORDS_PER_FRAME);

   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef logic [WCNT_W-1:0]          wcnt_t;

   typedef struct packed {
      sample_t re;
      sample_t im;
   } cplx_t;

   localparam wcnt_t LAST_WORD = wcnt_t'(WORDS_PER_FRAME - 1);
endpackage

// File: rtl/fft_frame_reg.sv
// 16-word register bank: one indexed word write per cycle, whole frame readable at once.
module fft_frame_reg
   import fft_pkg::*;
(
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             wr_en,
   input  wcnt_t                            wr_idx,
   input  sample_t                          wr_data,
   output sample_t [WORDS_PER_FRAME-1:0]    rd_frame
);

   sample_t [WORDS_PER_FRAME-1:0] mem_q, mem_d;

   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[wr_idx] = wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mem_q <= '0;
      else        mem_q <= mem_d;
   end

   assign rd_frame = mem_q;

endmodule

// File: rtl/fft_sample_loader.sv
// Double-buffered front-end: serial re/im words fill a shadow frame, which is copied to the
// FFT input registers once the previous frame has been held long enough. Optional FFT_LOADER_FRAME_ERR_EN adds in_first resync.
module fft_sample_loader
   import fft_pkg::*;
#(
   parameter int HOLD_CYCLES = 4
)(
   input  logic    clk,
   input  logic    rst,
   input  logic    in_valid,
   output logic    in_ready,
   input  sample_t in_data,
`ifdef FFT_LOADER_FRAME_ERR_EN
   input  logic    in_first,
   output logic    frame_err,
`endif
   output sample_t x0_re,
   output sample_t x0_im,
   output sample_t x1_re,
   output sample_t x1_im,
   output sample_t x2_re,
   output sample_t x2_im,
   output sample_t x3_re,
   output sample_t x3_im,
   output sample_t x4_re,
   output sample_t x4_im,
   output sample_t x5_re,
   output sample_t x5_im,
   output sample_t x6_re,
   output sample_t x6_im,
   output sample_t x7_re,
   output sample_t x7_im,
   output logic    frame_valid
);

   localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES);

   wcnt_t                         wcnt_q, wcnt_d;
   logic                          shadow_full_q, shadow_full_d;
   logic [7:0]                    hold_q, hold_d;
   logic                          frame_valid_q, frame_valid_d;
   cplx_t [NPOINT-1:0]            out_q, out_d;
   logic                          accept, transfer, wr_en;
   wcnt_t                         wr_idx;
   sample_t [WORDS_PER_FRAME-1:0] shadow;
`ifdef FFT_LOADER_FRAME_ERR_EN
   logic                          frame_err_q, frame_err_d;
`endif

   // in_ready is the inverse of a flop, so it is already registered
   assign in_ready = !shadow_full_q;
   assign accept   = in_valid && in_ready;
   assign transfer = shadow_full_q && (hold_q == '0);

   fft_frame_reg u_shadow (
      .clk      (clk),
      .rst_n    (rst),
      .wr_en    (wr_en),
      .wr_idx   (wr_idx),
      .wr_data  (in_data),
      .rd_frame (shadow)
   );

   always_comb begin
      wcnt_d        = wcnt_q;
      shadow_full_d = shadow_full_q;
      hold_d        = (hold_q != '0) ? hold_q - 8'd1 : 8'd0;
      out_d         = out_q;
      frame_valid_d = transfer;
      wr_en         = 1'b0;
      wr_idx        = wcnt_q;
`ifdef FFT_LOADER_FRAME_ERR_EN
      frame_err_d   = 1'b0;
`endif
      if (transfer) begin
         for (int i = 0; i < NPOINT; i++) begin
            out_d[i].re = shadow[2*i];
            out_d[i].im = shadow[2*i+1];
         end
         shadow_full_d = 1'b0;
         hold_d        = HOLD_LD;
      end
      // accept implies the shadow is empty, so it never collides with a transfer
      if (accept) begin
         wr_en  = 1'b1;
         wcnt_d = wcnt_q + 1'b1;
         if (wcnt_q == LAST_WORD) shadow_full_d = 1'b1;
`ifdef FFT_LOADER_FRAME_ERR_EN
         if (in_first && (wcnt_q != '0)) begin
            frame_err_d   = 1'b1;
            wr_idx        = '0;
            wcnt_d        = wcnt_t'(1);
            shadow_full_d = 1'b0;
         end else if (!in_first && (wcnt_q == '0)) begin
            frame_err_d   = 1'b1;
            wr_en         = 1'b0;
            wcnt_d        = '0;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt_q        <= '0;
         shadow_full_q <= 1'b0;
         hold_q        <= '0;
         frame_valid_q <= 1'b0;
         out_q         <= '0;
`ifdef FFT_LOADER_FRAME_ERR_EN
         frame_err_q   <= 1'b0;
`endif
      end else begin
         wcnt_q        <= wcnt_d;
         shadow_full_q <= shadow_full_d;
         hold_q        <= hold_d;
         frame_valid_q <= frame_valid_d;
         out_q         <= out_d;
`ifdef FFT_LOADER_FRAME_ERR_EN
         frame_err_q   <= frame_err_d;
`endif
      end
   end

`ifdef FFT_LOADER_FRAME_ERR_EN
   assign frame_err = frame_err_q;
`endif
   assign frame_valid = frame_valid_q;
   assign x0_re = out_q[0].re;
   assign x0_im = out_q[0].im;
   assign x1_re = out_q[1].re;
   assign x1_im = out_q[1].im;
   assign x2_re = out_q[2].re;
   assign x2_im = out_q[2].im;
   assign x3_re = out_q[3].re;
   assign x3_im = out_q[3].im;
   assign x4_re = out_q[4].re;
   assign x4_im = out_q[4].im;
   assign x5_re = out_q[5].re;
   assign x5_im = out_q[5].im;
   assign x6_re = out_q[6].re;
   assign x6_im = out_q[6].im;
   assign x7_re = out_q[7].re;
   assign x7_im = out_q[7].im;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Bench for fft_sample_loader: two instances (hold 4 and hold 20) checked every cycle against a frame-queue model.
module tb_fft_sample_loader;
   import fft_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             vld [2];
   logic             rdy [2];
   logic             fv  [2];
   sample_t          din [2];
   sample_t [15:0]   xo  [2];
`ifdef FFT_LOADER_FRAME_ERR_EN
   logic             fst  [2];
   logic             ferr [2];
`endif

   for (genvar k = 0; k < 2; k++) begin : g_dut
      fft_sample_loader #(.HOLD_CYCLES(k == 0 ? 4 : 20)) u_dut (
         .clk(clk), .rst(rst), .in_valid(vld[k]), .in_ready(rdy[k]), .in_data(din[k]),
`ifdef FFT_LOADER_FRAME_ERR_EN
         .in_first(fst[k]), .frame_err(ferr[k]),
`endif
         .x0_re(xo[k][0]),  .x0_im(xo[k][1]),  .x1_re(xo[k][2]),  .x1_im(xo[k][3]),
         .x2_re(xo[k][4]),  .x2_im(xo[k][5]),  .x3_re(xo[k][6]),  .x3_im(xo[k][7]),
         .x4_re(xo[k][8]),  .x4_im(xo[k][9]),  .x5_re(xo[k][10]), .x5_im(xo[k][11]),
         .x6_re(xo[k][12]), .x6_im(xo[k][13]), .x7_re(xo[k][14]), .x7_im(xo[k][15]),
         .frame_valid(fv[k]));
   end

   // reference: words collect in a queue; a complete frame waits until the hold has run out
   sample_t        mbuf  [2][$];
   sample_t        src   [2][$];
   sample_t [15:0] mpend [2];
   sample_t [15:0] mout  [2];
   bit             mfull [2];
   bit             mfv   [2];
   int             mhold [2];
   int             hcfg  [2] = '{4, 20};
   bit             gaps;
   int             cyc, checks, failures;
   int             fvt[$];

   task automatic chk(string tag, logic [143:0] obs, logic [143:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mbuf[k].delete();
         mpend[k] = '0;
         mout[k]  = '0;
         mfull[k] = 1'b0;
         mfv[k]   = 1'b0;
         mhold[k] = 0;
      end
   endtask

   task automatic model_edge(int k);
      bit acc, xfer;
      acc  = vld[k] && !mfull[k];
      xfer = mfull[k] && (mhold[k] == 0);
      mhold[k] = xfer ? hcfg[k] : (mhold[k] > 0 ? mhold[k] - 1 : 0);
      mfv[k]   = xfer;
      if (xfer) begin
         mout[k]  = mpend[k];
         mfull[k] = 1'b0;
      end
      if (acc) begin
         mbuf[k].push_back(din[k]);
         void'(src[k].pop_front());
         if (mbuf[k].size() == 16) begin
            for (int w = 0; w < 16; w++) mpend[k][w] = mbuf[k][w];
            mfull[k] = 1'b1;
            mbuf[k].delete();
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("in_ready[%0d] cyc%0d", k, cyc), 144'(rdy[k]), 144'(!mfull[k]));
         chk($sformatf("frame_valid[%0d] cyc%0d", k, cyc), 144'(fv[k]), 144'(mfv[k]));
         chk($sformatf("frame[%0d] cyc%0d", k, cyc), 144'(xo[k]), 144'(mout[k]));
`ifdef FFT_LOADER_FRAME_ERR_EN
         chk($sformatf("frame_err[%0d] cyc%0d", k, cyc), 144'(ferr[k]), 144'(0));
`endif
      end
   endtask

   task automatic drive();
      for (int k = 0; k < 2; k++) begin
         vld[k] = (src[k].size() > 0) && (!gaps || ($urandom_range(0, 1) == 1));
         din[k] = vld[k] ? src[k][0] : sample_t'($urandom);
`ifdef FFT_LOADER_FRAME_ERR_EN
         fst[k] = (mbuf[k].size() == 0);
`endif
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int k = 0; k < 2; k++) model_edge(k);
      end else begin
         model_reset();
      end
      #1;
      check_all();
      if (fv[0]) fvt.push_back(cyc);
      cyc++;
      drive();
   endtask

   function automatic bit drained();
      return src[0].size() == 0 && src[1].size() == 0 && mbuf[0].size() == 0 &&
             mbuf[1].size() == 0 && !mfull[0] && !mfull[1];
   endfunction

   initial begin
      checks = 0; failures = 0; cyc = 0; gaps = 1'b0;
      rst = 1'b0;
      model_reset();
      drive();
      repeat (3) tick();
      rst = 1'b1;

      // back-to-back frames 1..16 then 101..116
      for (int k = 0; k < 2; k++) begin
         for (int v = 1; v <= 16; v++) src[k].push_back(sample_t'(v));
         for (int v = 101; v <= 116; v++) src[k].push_back(sample_t'(v));
      end
      drive();
      repeat (70) tick();
      chk("fv_pulses_hold4", 144'(fvt.size()), 144'(2));
      if (fvt.size() == 2) chk("fv_spacing_hold4", 144'(fvt[1] - fvt[0]), 144'(17));

      // random in_valid gaps, one directed and one random frame
      gaps = 1'b1;
      for (int k = 0; k < 2; k++) begin
         for (int v = 1; v <= 16; v++) src[k].push_back(sample_t'(v));
         for (int v = 0; v < 16; v++) src[k].push_back(sample_t'($urandom));
      end
      drive();
      for (int i = 0; i < 800 && !drained(); i++) tick();
      chk("gap_stream_drained", 144'(drained()), 144'(1));
      gaps = 1'b0;
      repeat (30) tick();

      // reset after 9 words of a frame, then a clean frame 200..215
      for (int k = 0; k < 2; k++)
         for (int v = 0; v < 9; v++) src[k].push_back(sample_t'($urandom));
      drive();
      repeat (9) tick();
      rst = 1'b0;
      for (int k = 0; k < 2; k++) src[k].delete();
      #2;
      model_reset();
      check_all();
      drive();
      repeat (2) tick();
      rst = 1'b1;
      for (int k = 0; k < 2; k++)
         for (int v = 200; v <= 215; v++) src[k].push_back(sample_t'(v));
      drive();
      repeat (50) tick();
      for (int k = 0; k < 2; k++)
         chk($sformatf("x0_re_after_reset[%0d]", k), 144'(xo[k][0]), 144'(sample_t'(200)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
